// File: rtl/alu_mdu.sv
// Execute-stage ALU with a valid/ready input handshake and registered outputs.
// Multiply and divide run iteratively, one bit per cycle, over WIDTH cycles.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_flush,
  input  logic [3:0]       i_ctrl,
  input  logic [WIDTH-1:0] i_1,
  input  logic [WIDTH-1:0] i_2,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_minus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4,  OP_SRA  = 4'd5,  OP_SRL  = 4'd6,  OP_SLL  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8,  OP_MULH = 4'd9,  OP_DIV  = 4'd10, OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REM  = 4'd12, OP_REMU = 4'd13, OP_SLT  = 4'd14, OP_SLTU = 4'd15;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, mc_q;
  logic [2*WIDTH-1:0] p_q;
  logic               neg_q;
  logic [SHW-1:0]     cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic               valid_q, zero_q, minus_q;

  // True signed less-than: MSB of the difference corrected by overflow.
  function automatic logic lt_signed(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] d;
    d = x - y;
    return d[WIDTH-1] ^ ((x[WIDTH-1] ^ y[WIDTH-1]) & (d[WIDTH-1] ^ x[WIDTH-1]));
  endfunction

  logic [SHW-1:0]     sh_amt;
  logic [WIDTH-1:0]   alu_res;
  logic               in_multi, in_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  always_comb begin
    sh_amt  = i_2[SHW-1:0];
    alu_res = '0;
    case (i_ctrl)
      OP_ADD:  alu_res = i_1 + i_2;
      OP_SUB:  alu_res = i_1 - i_2;
      OP_AND:  alu_res = i_1 & i_2;
      OP_OR:   alu_res = i_1 | i_2;
      OP_XOR:  alu_res = i_1 ^ i_2;
      OP_SRA:  alu_res = $signed(i_1) >>> sh_amt;
      OP_SRL:  alu_res = i_1 >> sh_amt;
      OP_SLL:  alu_res = i_1 << sh_amt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt_signed(i_1, i_2)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (i_1 < i_2)};
      default: alu_res = '0;
    endcase
    in_multi  = (i_ctrl >= OP_MUL) && (i_ctrl <= OP_REMU);
    in_signed = (i_ctrl == OP_MULH) || (i_ctrl == OP_DIV) || (i_ctrl == OP_REM);
    a_neg     = in_signed & i_1[WIDTH-1];
    b_neg     = in_signed & i_2[WIDTH-1];
    a_mag     = a_neg ? -i_1 : i_1;
    b_mag     = b_neg ? -i_2 : i_2;
  end

  // One iteration of each engine; p_q holds {hi, lo} for both.
  logic               op_is_div;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] mul_next, div_next, step_next, mul_full;
  logic [WIDTH-1:0]   quo, rem, final_res;

  always_comb begin
    op_is_div = (op_q != OP_MUL) && (op_q != OP_MULH);
    mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mc_q} : '0);
    mul_next  = {mul_sum, p_q[WIDTH-1:1]};
    div_sh    = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    div_diff  = div_sh - {1'b0, mc_q};
    div_ok    = ~div_diff[WIDTH];
    div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]), p_q[WIDTH-2:0], div_ok};
    step_next = op_is_div ? div_next : mul_next;

    mul_full  = neg_q ? -mul_next : mul_next;
    quo       = div_next[WIDTH-1:0];
    rem       = div_next[2*WIDTH-1:WIDTH];
    final_res = '0;
    case (op_q)
      OP_MUL:          final_res = mul_full[WIDTH-1:0];
      OP_MULH:         final_res = mul_full[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU: final_res = (b_q == '0) ? '1 : (neg_q ? -quo : quo);
      default:         final_res = neg_q ? -rem : rem;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      mc_q     <= '0;
      p_q      <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
      minus_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            if (in_multi) begin
              op_q    <= i_ctrl;
              a_q     <= i_1;
              b_q     <= i_2;
              mc_q    <= b_mag;
              p_q     <= {{WIDTH{1'b0}}, a_mag};
              neg_q   <= (i_ctrl == OP_REM) ? a_neg : (a_neg ^ b_neg);
              cnt_q   <= '0;
              state_q <= BUSY;
            end else begin
              result_q <= alu_res;
              zero_q   <= (i_1 == i_2);
              minus_q  <= lt_signed(i_1, i_2);
              valid_q  <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (i_flush) begin
            state_q <= IDLE;
          end else begin
            p_q   <= step_next;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == SHW'(WIDTH-1)) begin
              result_q <= final_res;
              zero_q   <= (a_q == b_q);
              minus_q  <= lt_signed(a_q, b_q);
              valid_q  <= 1'b1;
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_zero   = zero_q;
  assign o_minus  = minus_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu at WIDTH=32: reset, single-cycle ops, iterative MUL/DIV, flags, flush.
module tb_alu_mdu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_flush;
  logic [3:0]  i_ctrl;
  logic [31:0] i_1, i_2;
  logic        o_ready, o_valid, o_zero, o_minus;
  logic [31:0] o_result;

  int errors = 0;
  int checks = 0;

  alu_mdu #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_flush(i_flush), .i_ctrl(i_ctrl), .i_1(i_1), .i_2(i_2),
    .o_valid(o_valid), .o_result(o_result), .o_zero(o_zero), .o_minus(o_minus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    i_ctrl  = c;
    i_1     = a;
    i_2     = b;
    i_valid = 1'b1;
  endtask

  // Accepts one multi-cycle op, then waits (bounded) for o_valid.
  task automatic run_multi(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int lat, output bit rdy_bad);
    rdy_bad = 1'b0;
    lat     = 0;
    drive(c, a, b);
    step();
    i_valid = 1'b0;
    while (o_valid !== 1'b1 && lat < 40) begin
      if (o_ready !== 1'b0) rdy_bad = 1'b1;
      step();
      lat++;
    end
    res = o_result;
    $display("multi op=%0d a=%h b=%h -> result=%h latency=%0d", c, a, b, res, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ctrl = 4'd0; i_1 = '0; i_2 = '0;
    #1;
    checks++;
    if (o_result !== 32'd0 || o_valid !== 1'b0) begin
      errors++; $display("FAIL reset_init result=%h valid=%b required 0/0", o_result, o_valid);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    drive(4'd14, 32'd1, 32'd2);
    step();
    i_valid = 1'b0;
    $display("SLT 1,2 -> result=%h minus=%b", o_result, o_minus);
    checks++;
    if (o_result !== 32'd1 || o_minus !== 1'b1) begin
      errors++; $display("FAIL slt_pre result=%h minus=%b required 1/1", o_result, o_minus);
    end
    drive(4'd10, 32'd100, 32'd7);
    step();
    i_valid = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    $display("reset mid-DIV -> result=%h valid=%b zero=%b minus=%b", o_result, o_valid, o_zero, o_minus);
    checks++;
    if (o_result !== 32'd0) begin errors++; $display("FAIL rst_result got=%h required 0", o_result); end
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b required 0", o_valid); end
    checks++;
    if (o_zero !== 1'b0 || o_minus !== 1'b0) begin
      errors++; $display("FAIL rst_flags zero=%b minus=%b required 0/0", o_zero, o_minus);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b required 1", o_ready); end
    drive(4'd0, 32'd3, 32'd4);
    step();
    i_valid = 1'b0;
    $display("ADD 3+4 -> valid=%b result=%h", o_valid, o_result);
    checks++;
    if (o_valid !== 1'b1 || o_result !== 32'd7) begin
      errors++; $display("FAIL add_after_rst valid=%b result=%h required 1/7", o_valid, o_result);
    end
    // A discarded DIV must not surface later.
    repeat (35) begin
      step();
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL stale_div valid=%b required 0", o_valid); end
    end
  endtask

  task automatic test_back_to_back();
    drive(4'd0, 32'hFFFF_FFFF, 32'd1);
    step();
    $display("ADD FFFFFFFF+1 -> valid=%b result=%h zero=%b", o_valid, o_result, o_zero);
    checks++;
    if (o_valid !== 1'b1 || o_result !== 32'd0 || o_zero !== 1'b0) begin
      errors++; $display("FAIL b2b_add valid=%b result=%h zero=%b required 1/0/0", o_valid, o_result, o_zero);
    end
    drive(4'd5, 32'h8000_0000, 32'h24);
    step();
    $display("SRA 80000000>>>24h -> valid=%b result=%h", o_valid, o_result);
    checks++;
    if (o_valid !== 1'b1 || o_result !== 32'hF800_0000) begin
      errors++; $display("FAIL b2b_sra valid=%b result=%h required 1/f8000000", o_valid, o_result);
    end
    drive(4'd15, 32'd1, 32'hFFFF_FFFF);
    step();
    i_valid = 1'b0;
    $display("SLTU 1,FFFFFFFF -> valid=%b result=%h", o_valid, o_result);
    checks++;
    if (o_valid !== 1'b1 || o_result !== 32'd1) begin
      errors++; $display("FAIL b2b_sltu valid=%b result=%h required 1/1", o_valid, o_result);
    end
    step();
    checks++;
    if (o_valid !== 1'b0 || o_result !== 32'd1) begin
      errors++; $display("FAIL valid_pulse valid=%b result=%h required 0/1", o_valid, o_result);
    end
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat; bit bad;
    run_multi(4'd9, 32'h8000_0000, 32'h8000_0000, r, lat, bad);
    checks++;
    if (r !== 32'h4000_0000) begin errors++; $display("FAIL mulh result=%h required 40000000", r); end
    checks++;
    if (lat != 32 || bad || o_ready !== 1'b1) begin
      errors++; $display("FAIL mulh_timing latency=%0d ready_bad=%0d ready=%b required 32/0/1", lat, bad, o_ready);
    end
    run_multi(4'd8, 32'hFFFF_FFFF, 32'd3, r, lat, bad);
    checks++;
    if (r !== 32'hFFFF_FFFD) begin errors++; $display("FAIL mul result=%h required fffffffd", r); end
    checks++;
    if (lat != 32 || bad || o_ready !== 1'b1) begin
      errors++; $display("FAIL mul_timing latency=%0d ready_bad=%0d ready=%b required 32/0/1", lat, bad, o_ready);
    end
  endtask

  task automatic test_div();
    logic [3:0]  ops [6] = '{4'd10, 4'd12, 4'd10, 4'd13, 4'd10, 4'd12};
    logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] r; int lat; bit bad;
    for (int i = 0; i < 6; i++) begin
      run_multi(ops[i], as[i], bs[i], r, lat, bad);
      checks++;
      if (r !== exp[i]) begin errors++; $display("FAIL div_%0d result=%h required %h", i, r, exp[i]); end
      checks++;
      if (lat != 32 || bad) begin
        errors++; $display("FAIL div_%0d_timing latency=%0d ready_bad=%0d required 32/0", i, lat, bad);
      end
      if (i == 0) begin
        checks++;
        if (o_minus !== 1'b1 || o_zero !== 1'b0) begin
          errors++; $display("FAIL div_flags minus=%b zero=%b required 1/0", o_minus, o_zero);
        end
      end
    end
  endtask

  task automatic test_flags();
    drive(4'd1, 32'h8000_0000, 32'd1);
    step();
    $display("SUB 80000000-1 -> result=%h minus=%b zero=%b", o_result, o_minus, o_zero);
    checks++;
    if (o_result !== 32'h7FFF_FFFF || o_minus !== 1'b1 || o_zero !== 1'b0) begin
      errors++; $display("FAIL sub_ovf result=%h minus=%b zero=%b required 7fffffff/1/0", o_result, o_minus, o_zero);
    end
    drive(4'd1, 32'd9, 32'd9);
    step();
    i_valid = 1'b0;
    $display("SUB 9-9 -> result=%h minus=%b zero=%b", o_result, o_minus, o_zero);
    checks++;
    if (o_result !== 32'd0 || o_zero !== 1'b1 || o_minus !== 1'b0) begin
      errors++; $display("FAIL sub_eq result=%h zero=%b minus=%b required 0/1/0", o_result, o_zero, o_minus);
    end
  endtask

  task automatic test_flush();
    int pulses = 0;
    logic [31:0] r; int lat; bit bad;
    drive(4'd4, 32'hA5, 32'h0F);
    step();
    checks++;
    if (o_result !== 32'hAA) begin errors++; $display("FAIL xor result=%h required aa", o_result); end
    drive(4'd8, 32'd6, 32'd7);
    step();
    drive(4'd0, 32'd1, 32'd1);  // held during BUSY, must be ignored
    repeat (9) begin
      step();
      if (o_valid === 1'b1) pulses++;
    end
    i_valid = 1'b0;
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    $display("flush MUL -> valid=%b ready=%b result=%h", o_valid, o_ready, o_result);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== 32'hAA) begin
      errors++; $display("FAIL flush valid=%b ready=%b result=%h required 0/1/aa", o_valid, o_ready, o_result);
    end
    repeat (40) begin
      step();
      if (o_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || o_result !== 32'hAA) begin
      errors++; $display("FAIL flush_quiet pulses=%0d result=%h required 0/aa", pulses, o_result);
    end
    run_multi(4'd8, 32'd6, 32'd7, r, lat, bad);
    checks++;
    if (r !== 32'd42 || lat != 32) begin
      errors++; $display("FAIL mul_after_flush result=%h latency=%0d required 2a/32", r, lat);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_div();
    test_flags();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
